// File: rtl/ex_longp_wbck.sv
// Long-pipe writeback collector: captures out-of-order LSU/MULDIV results into
// per-tag slots and drains them in OITF order through one output register.
module ex_longp_wbck #(
    parameter int unsigned OITF_DEPTH  = 2,
    parameter int unsigned ITAG_WIDTH  = 1,
    parameter int unsigned RFIDX_WIDTH = 5,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PC_SIZE     = 32
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   lsu_o_valid,
    output logic                   lsu_o_ready,
    input  logic [ITAG_WIDTH-1:0]  lsu_o_itag,
    input  logic [XLEN-1:0]        lsu_o_wdat,
    input  logic                   lsu_o_err,
    input  logic [XLEN-1:0]        lsu_o_badaddr,

    input  logic                   mdv_o_valid,
    output logic                   mdv_o_ready,
    input  logic [ITAG_WIDTH-1:0]  mdv_o_itag,
    input  logic [XLEN-1:0]        mdv_o_wdat,

    input  logic                   oitf_empty,
    input  logic [ITAG_WIDTH-1:0]  oitf_ret_ptr,
    input  logic [RFIDX_WIDTH-1:0] oitf_ret_rdidx,
    input  logic                   oitf_ret_rdwen,
    input  logic [PC_SIZE-1:0]     oitf_ret_pc,
    output logic                   oitf_ret_ena,

    output logic                   wbck_o_valid,
    input  logic                   wbck_o_ready,
    output logic [XLEN-1:0]        wbck_o_wdat,
    output logic [RFIDX_WIDTH-1:0] wbck_o_rdidx,

    output logic                   excp_o_valid,
    input  logic                   excp_o_ready,
    output logic [PC_SIZE-1:0]     excp_o_pc,
    output logic [XLEN-1:0]        excp_o_badaddr
);

    // Result slots, one per tag
    logic [OITF_DEPTH-1:0] slot_vld_q, slot_vld_d;
    logic [OITF_DEPTH-1:0] slot_err_q, slot_err_d;
    logic [XLEN-1:0]       slot_wdat_q    [OITF_DEPTH];
    logic [XLEN-1:0]       slot_wdat_d    [OITF_DEPTH];
    logic [XLEN-1:0]       slot_badaddr_q [OITF_DEPTH];
    logic [XLEN-1:0]       slot_badaddr_d [OITF_DEPTH];

    // Output register
    logic                   wbck_vld_q, wbck_vld_d;
    logic [XLEN-1:0]        wbck_wdat_q, wbck_wdat_d;
    logic [RFIDX_WIDTH-1:0] wbck_rdidx_q, wbck_rdidx_d;
    logic                   excp_vld_q, excp_vld_d;
    logic [PC_SIZE-1:0]     excp_pc_q, excp_pc_d;
    logic [XLEN-1:0]        excp_badaddr_q, excp_badaddr_d;

    logic tag_clash;
    logic lsu_hs;
    logic mdv_hs;
    logic wbck_hs;
    logic excp_hs;
    logic out_free;
    logic ret_ena;

    // Fill handshakes; on a same-tag collision the LSU wins
    always_comb begin
        tag_clash   = lsu_o_valid & (lsu_o_itag == mdv_o_itag);
        lsu_o_ready = ~slot_vld_q[lsu_o_itag];
        mdv_o_ready = ~slot_vld_q[mdv_o_itag] & ~tag_clash;
        lsu_hs      = lsu_o_valid & lsu_o_ready;
        mdv_hs      = mdv_o_valid & mdv_o_ready;
        wbck_hs     = wbck_vld_q & wbck_o_ready;
        excp_hs     = excp_vld_q & excp_o_ready;
        out_free    = ~(wbck_vld_q | excp_vld_q) | wbck_hs | excp_hs;
        ret_ena     = ~oitf_empty & slot_vld_q[oitf_ret_ptr] & out_free;
    end

    assign oitf_ret_ena = ret_ena;

    // Slot next state: clear the retiring head, write accepted results
    always_comb begin
        slot_vld_d     = slot_vld_q;
        slot_err_d     = slot_err_q;
        slot_wdat_d    = slot_wdat_q;
        slot_badaddr_d = slot_badaddr_q;
        for (int i = 0; i < int'(OITF_DEPTH); i++) begin
            if (ret_ena && (oitf_ret_ptr == ITAG_WIDTH'(i))) begin
                slot_vld_d[i] = 1'b0;
            end
            if (lsu_hs && (lsu_o_itag == ITAG_WIDTH'(i))) begin
                slot_vld_d[i]     = 1'b1;
                slot_err_d[i]     = lsu_o_err;
                slot_wdat_d[i]    = lsu_o_wdat;
                slot_badaddr_d[i] = lsu_o_badaddr;
            end
            if (mdv_hs && (mdv_o_itag == ITAG_WIDTH'(i))) begin
                slot_vld_d[i]     = 1'b1;
                slot_err_d[i]     = 1'b0;
                slot_wdat_d[i]    = mdv_o_wdat;
                slot_badaddr_d[i] = '0;
            end
        end
    end

    // Output register next state: load on retire, otherwise drop on handshake
    always_comb begin
        wbck_vld_d     = wbck_vld_q;
        wbck_wdat_d    = wbck_wdat_q;
        wbck_rdidx_d   = wbck_rdidx_q;
        excp_vld_d     = excp_vld_q;
        excp_pc_d      = excp_pc_q;
        excp_badaddr_d = excp_badaddr_q;
        if (ret_ena) begin
            wbck_vld_d = 1'b0;
            excp_vld_d = 1'b0;
            if (slot_err_q[oitf_ret_ptr]) begin
                excp_vld_d     = 1'b1;
                excp_pc_d      = oitf_ret_pc;
                excp_badaddr_d = slot_badaddr_q[oitf_ret_ptr];
            end else if (oitf_ret_rdwen) begin
                wbck_vld_d   = 1'b1;
                wbck_wdat_d  = slot_wdat_q[oitf_ret_ptr];
                wbck_rdidx_d = oitf_ret_rdidx;
            end
        end else begin
            if (wbck_hs) wbck_vld_d = 1'b0;
            if (excp_hs) excp_vld_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld_q     <= '0;
            slot_err_q     <= '0;
            for (int i = 0; i < int'(OITF_DEPTH); i++) begin
                slot_wdat_q[i]    <= '0;
                slot_badaddr_q[i] <= '0;
            end
            wbck_vld_q     <= 1'b0;
            wbck_wdat_q    <= '0;
            wbck_rdidx_q   <= '0;
            excp_vld_q     <= 1'b0;
            excp_pc_q      <= '0;
            excp_badaddr_q <= '0;
        end else begin
            slot_vld_q     <= slot_vld_d;
            slot_err_q     <= slot_err_d;
            slot_wdat_q    <= slot_wdat_d;
            slot_badaddr_q <= slot_badaddr_d;
            wbck_vld_q     <= wbck_vld_d;
            wbck_wdat_q    <= wbck_wdat_d;
            wbck_rdidx_q   <= wbck_rdidx_d;
            excp_vld_q     <= excp_vld_d;
            excp_pc_q      <= excp_pc_d;
            excp_badaddr_q <= excp_badaddr_d;
        end
    end

    assign wbck_o_valid   = wbck_vld_q;
    assign wbck_o_wdat    = wbck_wdat_q;
    assign wbck_o_rdidx   = wbck_rdidx_q;
    assign excp_o_valid   = excp_vld_q;
    assign excp_o_pc      = excp_pc_q;
    assign excp_o_badaddr = excp_badaddr_q;

endmodule

// File: tb/tb_ex_longp_wbck.sv
// Bench for ex_longp_wbck: directed vector table, hand-written corner
// sequences, and a randomized OITF/LSU/MULDIV run against a scoreboard.
module tb_ex_longp_wbck;

    logic        clk;
    logic        rst;
    logic        lsu_o_valid, lsu_o_ready, lsu_o_itag, lsu_o_err;
    logic [31:0] lsu_o_wdat, lsu_o_badaddr;
    logic        mdv_o_valid, mdv_o_ready, mdv_o_itag;
    logic [31:0] mdv_o_wdat;
    logic        oitf_empty, oitf_ret_ptr, oitf_ret_rdwen, oitf_ret_ena;
    logic [4:0]  oitf_ret_rdidx;
    logic [31:0] oitf_ret_pc;
    logic        wbck_o_valid, wbck_o_ready;
    logic [31:0] wbck_o_wdat;
    logic [4:0]  wbck_o_rdidx;
    logic        excp_o_valid, excp_o_ready;
    logic [31:0] excp_o_pc, excp_o_badaddr;

    ex_longp_wbck #(
        .OITF_DEPTH(2), .ITAG_WIDTH(1), .RFIDX_WIDTH(5), .XLEN(32), .PC_SIZE(32)
    ) dut (
        .clk(clk), .rst(rst),
        .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready), .lsu_o_itag(lsu_o_itag),
        .lsu_o_wdat(lsu_o_wdat), .lsu_o_err(lsu_o_err), .lsu_o_badaddr(lsu_o_badaddr),
        .mdv_o_valid(mdv_o_valid), .mdv_o_ready(mdv_o_ready), .mdv_o_itag(mdv_o_itag),
        .mdv_o_wdat(mdv_o_wdat),
        .oitf_empty(oitf_empty), .oitf_ret_ptr(oitf_ret_ptr), .oitf_ret_rdidx(oitf_ret_rdidx),
        .oitf_ret_rdwen(oitf_ret_rdwen), .oitf_ret_pc(oitf_ret_pc), .oitf_ret_ena(oitf_ret_ena),
        .wbck_o_valid(wbck_o_valid), .wbck_o_ready(wbck_o_ready), .wbck_o_wdat(wbck_o_wdat),
        .wbck_o_rdidx(wbck_o_rdidx),
        .excp_o_valid(excp_o_valid), .excp_o_ready(excp_o_ready), .excp_o_pc(excp_o_pc),
        .excp_o_badaddr(excp_o_badaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        lsu_o_valid = 0; lsu_o_itag = 0; lsu_o_wdat = 0; lsu_o_err = 0; lsu_o_badaddr = 0;
        mdv_o_valid = 0; mdv_o_itag = 0; mdv_o_wdat = 0;
        oitf_empty = 1; oitf_ret_ptr = 0; oitf_ret_rdidx = 0; oitf_ret_rdwen = 0; oitf_ret_pc = 0;
        wbck_o_ready = 1; excp_o_ready = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    // Directed single-instruction vectors with hand-derived expectations
    typedef struct {
        logic        is_lsu;
        logic        tag;
        logic [31:0] wdat;
        logic        err;
        logic [31:0] badaddr;
        logic [4:0]  rdidx;
        logic        rdwen;
        logic [31:0] pc;
        logic        exp_wbck;
        logic        exp_excp;
        logic [31:0] exp_a;   // wdat for wbck, pc for excp
        logic [31:0] exp_b;   // rdidx for wbck, badaddr for excp
    } vec_t;

    vec_t vecs[6];

    task automatic apply_vec(input vec_t v, input int k);
        oitf_empty = 0; oitf_ret_ptr = v.tag; oitf_ret_rdidx = v.rdidx;
        oitf_ret_rdwen = v.rdwen; oitf_ret_pc = v.pc;
        if (v.is_lsu) begin
            lsu_o_valid = 1; lsu_o_itag = v.tag; lsu_o_wdat = v.wdat;
            lsu_o_err = v.err; lsu_o_badaddr = v.badaddr;
        end else begin
            mdv_o_valid = 1; mdv_o_itag = v.tag; mdv_o_wdat = v.wdat;
        end
        at_neg();
        chk($sformatf("v%0d_ready", k), v.is_lsu ? lsu_o_ready : mdv_o_ready, 1);
        chk($sformatf("v%0d_noret_n", k), oitf_ret_ena, 0);
        tick();
        lsu_o_valid = 0; mdv_o_valid = 0;
        at_neg();
        chk($sformatf("v%0d_ret_n1", k), oitf_ret_ena, 1);
        chk($sformatf("v%0d_wv_n1", k), wbck_o_valid, 0);
        tick();
        oitf_empty = 1;
        at_neg();
        chk($sformatf("v%0d_wbck_v", k), wbck_o_valid, v.exp_wbck);
        chk($sformatf("v%0d_excp_v", k), excp_o_valid, v.exp_excp);
        chk($sformatf("v%0d_ret_n2", k), oitf_ret_ena, 0);
        if (v.exp_wbck) begin
            chk($sformatf("v%0d_wdat", k), wbck_o_wdat, v.exp_a);
            chk($sformatf("v%0d_rdidx", k), wbck_o_rdidx, v.exp_b);
        end
        if (v.exp_excp) begin
            chk($sformatf("v%0d_pc", k), excp_o_pc, v.exp_a);
            chk($sformatf("v%0d_bad", k), excp_o_badaddr, v.exp_b);
        end
        tick();
        at_neg();
        chk($sformatf("v%0d_drop", k), {wbck_o_valid, excp_o_valid}, 0);
        tick();
    endtask

    // Random-phase reference: OITF contents in program order, expected output stream
    typedef struct {
        logic        tag;
        logic        is_lsu;
        logic        err;
        logic [31:0] wdat;
        logic [31:0] badaddr;
        logic [31:0] pc;
        logic [4:0]  rdidx;
        logic        rdwen;
        logic        done;
    } ins_t;

    typedef struct {
        logic        is_excp;
        logic [31:0] a;
        logic [31:0] b;
    } tx_t;

    ins_t oq[$];
    tx_t  expq[$];

    task automatic rand_cycle(input logic alloc_en, inout logic next_tag,
                              inout logic lsu_busy, inout logic mdv_busy,
                              inout int n_alloc, inout int n_ret);
        ins_t in;
        tx_t  t;
        int   cand[$];
        int   pick;
        if (alloc_en && oq.size() < 2 && $urandom_range(0, 2) != 0) begin
            in.tag = next_tag; next_tag = ~next_tag;
            in.is_lsu  = 1'($urandom_range(0, 1));
            in.err     = in.is_lsu && ($urandom_range(0, 3) == 0);
            in.wdat    = $urandom;
            in.badaddr = $urandom;
            in.pc      = $urandom;
            in.rdidx   = 5'($urandom_range(0, 31));
            in.rdwen   = ($urandom_range(0, 4) != 0);
            in.done    = 0;
            oq.push_back(in);
            n_alloc++;
            if (in.err) begin
                t.is_excp = 1; t.a = in.pc; t.b = in.badaddr; expq.push_back(t);
            end else if (in.rdwen) begin
                t.is_excp = 0; t.a = in.wdat; t.b = 32'(in.rdidx); expq.push_back(t);
            end
        end
        if (!lsu_busy && $urandom_range(0, 1) == 1) begin
            cand = {};
            foreach (oq[i]) if (oq[i].is_lsu && !oq[i].done) cand.push_back(i);
            if (cand.size() > 0) begin
                pick = cand[$urandom_range(0, cand.size() - 1)];
                lsu_busy = 1; lsu_o_itag = oq[pick].tag; lsu_o_wdat = oq[pick].wdat;
                lsu_o_err = oq[pick].err; lsu_o_badaddr = oq[pick].badaddr;
            end
        end
        if (!mdv_busy && $urandom_range(0, 1) == 1) begin
            cand = {};
            foreach (oq[i]) if (!oq[i].is_lsu && !oq[i].done) cand.push_back(i);
            if (cand.size() > 0) begin
                pick = cand[$urandom_range(0, cand.size() - 1)];
                mdv_busy = 1; mdv_o_itag = oq[pick].tag; mdv_o_wdat = oq[pick].wdat;
            end
        end
        lsu_o_valid = lsu_busy;
        mdv_o_valid = mdv_busy;
        oitf_empty = (oq.size() == 0);
        if (oq.size() > 0) begin
            oitf_ret_ptr = oq[0].tag; oitf_ret_rdidx = oq[0].rdidx;
            oitf_ret_rdwen = oq[0].rdwen; oitf_ret_pc = oq[0].pc;
        end
        wbck_o_ready = ($urandom_range(0, 3) != 0);
        excp_o_ready = ($urandom_range(0, 3) != 0);
        at_neg();
        if (wbck_o_valid && excp_o_valid) chk("r_both_valid", 1, 0);
        if (oitf_ret_ena) begin
            chk("r_ret_nonempty", oq.size() > 0, 1);
            if (oq.size() > 0) begin
                chk("r_ret_head_done", oq[0].done, 1);
                void'(oq.pop_front());
                n_ret++;
            end
        end
        if (lsu_o_valid && lsu_o_ready) begin
            foreach (oq[i]) if (oq[i].tag == lsu_o_itag && oq[i].is_lsu) oq[i].done = 1;
            lsu_busy = 0;
        end
        if (mdv_o_valid && mdv_o_ready) begin
            foreach (oq[i]) if (oq[i].tag == mdv_o_itag && !oq[i].is_lsu) oq[i].done = 1;
            mdv_busy = 0;
        end
        if (wbck_o_valid && wbck_o_ready) begin
            chk("r_wbck_expected", expq.size() > 0, 1);
            if (expq.size() > 0) begin
                t = expq.pop_front();
                chk("r_wbck_kind", t.is_excp, 0);
                chk("r_wbck_wdat", wbck_o_wdat, t.a);
                chk("r_wbck_rdidx", 32'(wbck_o_rdidx), t.b);
            end
        end
        if (excp_o_valid && excp_o_ready) begin
            chk("r_excp_expected", expq.size() > 0, 1);
            if (expq.size() > 0) begin
                t = expq.pop_front();
                chk("r_excp_kind", t.is_excp, 1);
                chk("r_excp_pc", excp_o_pc, t.a);
                chk("r_excp_bad", excp_o_badaddr, t.b);
            end
        end
        tick();
    endtask

    initial begin
        logic next_tag, lsu_busy, mdv_busy;
        int   n_alloc, n_ret, guard;

        vecs[0] = '{0, 0, 32'h11,       0, 32'h0,         5'd5,  1, 32'h40,   1, 0, 32'h11,       32'd5};
        vecs[1] = '{1, 1, 32'hAA,       0, 32'h0,         5'd7,  1, 32'h44,   1, 0, 32'hAA,       32'd7};
        vecs[2] = '{1, 0, 32'h55,       1, 32'h8000_0004, 5'd3,  1, 32'h100,  0, 1, 32'h100,      32'h8000_0004};
        vecs[3] = '{0, 1, 32'h77,       0, 32'h0,         5'd9,  0, 32'h48,   0, 0, 32'h0,        32'h0};
        vecs[4] = '{1, 1, 32'h99,       1, 32'h1234,      5'd2,  0, 32'h2000, 0, 1, 32'h2000,     32'h1234};
        vecs[5] = '{1, 0, 32'hFFFF_FFFF, 0, 32'h0,        5'd31, 1, 32'h4C,   1, 0, 32'hFFFF_FFFF, 32'd31};

        do_reset();
        at_neg();
        chk("rst_wbck_v", wbck_o_valid, 0);
        chk("rst_excp_v", excp_o_valid, 0);
        chk("rst_ret", oitf_ret_ena, 0);
        chk("rst_data", {wbck_o_wdat, excp_o_pc}, 0);
        chk("rst_bad_rd", {excp_o_badaddr, 27'd0, wbck_o_rdidx}, 0);
        tick();

        for (int k = 0; k < 6; k++) apply_vec(vecs[k], k);

        // Out-of-order: tag1 arrives first, drains after tag0 on consecutive cycles
        oitf_empty = 0; oitf_ret_ptr = 0; oitf_ret_rdidx = 3; oitf_ret_rdwen = 1;
        lsu_o_valid = 1; lsu_o_itag = 1; lsu_o_wdat = 32'hAA; lsu_o_err = 0;
        tick();
        lsu_o_valid = 0;
        at_neg(); chk("ooo_hold_tag1", oitf_ret_ena, 0);
        tick();
        mdv_o_valid = 1; mdv_o_itag = 0; mdv_o_wdat = 32'hBB;
        at_neg(); chk("ooo_mdv_ready", mdv_o_ready, 1);
        tick();
        mdv_o_valid = 0;
        at_neg(); chk("ooo_ret0", oitf_ret_ena, 1);
        tick();
        oitf_ret_ptr = 1; oitf_ret_rdidx = 4;
        at_neg();
        chk("ooo_wdat0", wbck_o_wdat, 32'hBB);
        chk("ooo_rd0", wbck_o_rdidx, 3);
        chk("ooo_ret1", oitf_ret_ena, 1);
        tick();
        oitf_empty = 1;
        at_neg();
        chk("ooo_v1", wbck_o_valid, 1);
        chk("ooo_wdat1", wbck_o_wdat, 32'hAA);
        chk("ooo_rd1", wbck_o_rdidx, 4);
        tick();

        // Backpressure: output held while ready is low, retire resumes as ready rises
        wbck_o_ready = 0;
        oitf_empty = 0; oitf_ret_ptr = 0; oitf_ret_rdidx = 1; oitf_ret_rdwen = 1;
        lsu_o_valid = 1; lsu_o_itag = 0; lsu_o_wdat = 32'h10; lsu_o_err = 0;
        mdv_o_valid = 1; mdv_o_itag = 1; mdv_o_wdat = 32'h20;
        tick();
        lsu_o_valid = 0; mdv_o_valid = 0;
        at_neg(); chk("bp_ret0", oitf_ret_ena, 1);
        tick();
        oitf_ret_ptr = 1; oitf_ret_rdidx = 2;
        for (int c = 0; c < 5; c++) begin
            at_neg();
            chk($sformatf("bp_noret_%0d", c), oitf_ret_ena, 0);
            chk($sformatf("bp_hold_%0d", c), {wbck_o_valid, wbck_o_wdat}, {1'b1, 32'h10});
            tick();
        end
        wbck_o_ready = 1;
        at_neg(); chk("bp_ret1", oitf_ret_ena, 1);
        tick();
        oitf_empty = 1;
        at_neg();
        chk("bp_wdat1", {wbck_o_valid, wbck_o_wdat, wbck_o_rdidx}, {1'b1, 32'h20, 5'd2});
        tick();

        // Collision: LSU wins, MULDIV accepted after slot1 clears; orphan then retired
        oitf_empty = 0; oitf_ret_ptr = 1; oitf_ret_rdidx = 9; oitf_ret_rdwen = 1;
        lsu_o_valid = 1; lsu_o_itag = 1; lsu_o_wdat = 32'h33;
        mdv_o_valid = 1; mdv_o_itag = 1; mdv_o_wdat = 32'h44;
        at_neg();
        chk("col_lsu_rdy", lsu_o_ready, 1);
        chk("col_mdv_rdy", mdv_o_ready, 0);
        tick();
        lsu_o_valid = 0;
        at_neg();
        chk("col_full_mdv", mdv_o_ready, 0);
        chk("col_ret", oitf_ret_ena, 1);
        tick();
        oitf_empty = 1;
        at_neg();
        chk("col_mdv_acc", mdv_o_ready, 1);
        chk("col_wbck", {wbck_o_valid, wbck_o_wdat, wbck_o_rdidx}, {1'b1, 32'h33, 5'd9});
        tick();
        mdv_o_valid = 0;
        at_neg(); chk("orphan_held", oitf_ret_ena, 0);
        tick();
        at_neg(); chk("orphan_full", lsu_o_ready, 0);
        tick();
        oitf_empty = 0; oitf_ret_rdidx = 10;
        at_neg(); chk("orphan_ret", oitf_ret_ena, 1);
        tick();
        oitf_empty = 1;
        at_neg(); chk("orphan_wbck", {wbck_o_valid, wbck_o_wdat, wbck_o_rdidx}, {1'b1, 32'h44, 5'd10});
        tick();

        // Reset with both slots full and output occupied
        wbck_o_ready = 0;
        lsu_o_valid = 1; lsu_o_itag = 0; lsu_o_wdat = 32'h5A;
        mdv_o_valid = 1; mdv_o_itag = 1; mdv_o_wdat = 32'hA5;
        tick();
        lsu_o_valid = 0; mdv_o_valid = 0;
        oitf_empty = 0; oitf_ret_ptr = 0; oitf_ret_rdidx = 6; oitf_ret_rdwen = 1;
        tick();
        oitf_ret_ptr = 1;
        at_neg();
        chk("rstm_pre_v", wbck_o_valid, 1);
        rst = 1;
        lsu_o_itag = 1;
        #1;
        chk("rstm_wbck_v", {wbck_o_valid, excp_o_valid, oitf_ret_ena}, 0);
        chk("rstm_data", wbck_o_wdat, 0);
        chk("rstm_slot_free", lsu_o_ready, 1);
        tick();
        idle_inputs();
        rst = 0;
        tick();

        // Randomized run against the scoreboard, then drain
        oq = {}; expq = {};
        next_tag = 0; lsu_busy = 0; mdv_busy = 0; n_alloc = 0; n_ret = 0;
        for (int c = 0; c < 800; c++) rand_cycle(1, next_tag, lsu_busy, mdv_busy, n_alloc, n_ret);
        guard = 0;
        while ((oq.size() > 0 || expq.size() > 0 || lsu_busy || mdv_busy) && guard < 2000) begin
            rand_cycle(0, next_tag, lsu_busy, mdv_busy, n_alloc, n_ret);
            guard++;
        end
        chk("r_drain_done", guard < 2000, 1);
        chk("r_retire_count", 32'(n_ret), 32'(n_alloc));
        chk("r_exp_empty", 32'(expq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
